// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control units: opcodes, FSM states, datapath select codes.
// Also provides the opcode-class type and the DECODE dispatch helper.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_ADDI_EXEC = 4'd8,
        S_ADDI_WB   = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_ERROR     = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    typedef enum logic [3:0] {
        OPC_RTYPE,
        OPC_LW,
        OPC_SW,
        OPC_ADDI,
        OPC_BEQ,
        OPC_BNE,
        OPC_J,
        OPC_JAL,
        OPC_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_ncond;
        logic       iord;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_toreg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       err_illegal_opcode;
    } ctrl_out_t;

    function automatic state_t decode_target(input op_class_t c);
        state_t t;
        case (c)
            OPC_LW, OPC_SW:   t = S_MEM_ADDR;
            OPC_RTYPE:        t = S_R_EXEC;
            OPC_ADDI:         t = S_ADDI_EXEC;
            OPC_BEQ, OPC_BNE: t = S_BRANCH;
            OPC_J, OPC_JAL:   t = S_JUMP;
            default:          t = S_ERROR;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/ctrl_opcode_class.sv
// Combinational opcode classifier shared by the single-cycle and multicycle decoders.
// With EXT_OPS_EN=0, bne and jal fall into the illegal class.
module ctrl_opcode_class
    import mips_ctrl_pkg::*;
#(
    parameter bit EXT_OPS_EN = 1'b1
) (
    input  logic [5:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = OPC_ILLEGAL;
        case (opcode)
            OP_RTYPE: op_class = OPC_RTYPE;
            OP_LW:    op_class = OPC_LW;
            OP_SW:    op_class = OPC_SW;
            OP_ADDI:  op_class = OPC_ADDI;
            OP_BEQ:   op_class = OPC_BEQ;
            OP_J:     op_class = OPC_J;
            OP_BNE:   op_class = EXT_OPS_EN ? OPC_BNE : OPC_ILLEGAL;
            OP_JAL:   op_class = EXT_OPS_EN ? OPC_JAL : OPC_ILLEGAL;
            default:  op_class = OPC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_32.sv
// Multicycle MIPS control FSM: Moore outputs from the registered state, with only the
// FETCH ir_write/pc_write gated by mem_ready. Reset blanks every output while held.
module multicycle_control_32
    import mips_ctrl_pkg::*;
#(
    parameter bit MEM_WAIT_EN     = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter bit EXT_OPS_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_write_ncond,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_toreg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] reg_dst,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       err_illegal_opcode,
    output logic [3:0] state_dbg
);

    state_t    state_reg, state_next;
    op_class_t op_class;
    op_class_t op_class_reg, op_class_next;
    ctrl_out_t co, co_out;
    logic      ready;

    ctrl_opcode_class #(.EXT_OPS_EN(EXT_OPS_EN)) u_class (
        .opcode   (opcode),
        .op_class (op_class)
    );

    assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_FETCH;
            op_class_reg <= OPC_ILLEGAL;
        end else begin
            state_reg    <= state_next;
            op_class_reg <= op_class_next;
        end
    end

    // The class is captured at the end of DECODE so later states never look at the live opcode.
    always_comb begin
        state_next    = state_reg;
        op_class_next = op_class_reg;
        case (state_reg)
            S_FETCH:     if (ready) state_next = S_DECODE;
            S_DECODE: begin
                state_next    = decode_target(op_class);
                op_class_next = op_class;
            end
            S_MEM_ADDR:  state_next = (op_class_reg == OPC_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    if (ready) state_next = S_MEM_WB;
            S_MEM_WB:    state_next = S_FETCH;
            S_MEM_WR:    if (ready) state_next = S_FETCH;
            S_R_EXEC:    state_next = S_R_WB;
            S_R_WB:      state_next = S_FETCH;
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            S_ADDI_WB:   state_next = S_FETCH;
            S_BRANCH:    state_next = S_FETCH;
            S_JUMP:      state_next = S_FETCH;
            S_ERROR:     if (!TRAP_ON_ILLEGAL) state_next = S_FETCH;
            default:     state_next = S_FETCH;
        endcase
    end

    always_comb begin
        co = '0;
        case (state_reg)
            S_FETCH: begin
                co.mem_read  = 1'b1;
                co.alu_src_b = SRCB_FOUR;
                co.alu_op    = ALU_ADD;
                co.pc_source = PC_ALU;
                co.ir_write  = ready;
                co.pc_write  = ready;
            end
            S_DECODE: begin
                co.alu_src_b = SRCB_IMM_SH2;
                co.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                co.alu_src_a = 1'b1;
                co.alu_src_b = SRCB_IMM;
                co.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                co.mem_read = 1'b1;
                co.iord     = 1'b1;
            end
            S_MEM_WB: begin
                co.reg_write = 1'b1;
                co.mem_toreg = 1'b1;
                co.reg_dst   = RDST_RT;
            end
            S_MEM_WR: begin
                co.mem_write = 1'b1;
                co.iord      = 1'b1;
            end
            S_R_EXEC: begin
                co.alu_src_a = 1'b1;
                co.alu_src_b = SRCB_REG;
                co.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                co.reg_write = 1'b1;
                co.reg_dst   = RDST_RD;
            end
            S_ADDI_WB: begin
                co.reg_write = 1'b1;
                co.reg_dst   = RDST_RT;
            end
            S_BRANCH: begin
                co.alu_src_a      = 1'b1;
                co.alu_src_b      = SRCB_REG;
                co.alu_op         = ALU_SUB;
                co.pc_source      = PC_ALUOUT;
                co.pc_write_cond  = (op_class_reg == OPC_BEQ);
                co.pc_write_ncond = (op_class_reg == OPC_BNE);
            end
            S_JUMP: begin
                co.pc_write  = 1'b1;
                co.pc_source = PC_JUMP;
                if (op_class_reg == OPC_JAL) begin
                    co.reg_write = 1'b1;
                    co.reg_dst   = RDST_RA;
                    co.alu_src_b = SRCB_FOUR;
                end
            end
            S_ERROR:  co.err_illegal_opcode = 1'b1;
            default:  co = '0;
        endcase
    end

    // FETCH drives mem_read, so outputs are blanked combinationally while rst is held.
    assign co_out = rst ? '0 : co;

    assign pc_write           = co_out.pc_write;
    assign pc_write_cond      = co_out.pc_write_cond;
    assign pc_write_ncond     = co_out.pc_write_ncond;
    assign iord               = co_out.iord;
    assign ir_write           = co_out.ir_write;
    assign mem_read           = co_out.mem_read;
    assign mem_write          = co_out.mem_write;
    assign mem_toreg          = co_out.mem_toreg;
    assign reg_write          = co_out.reg_write;
    assign alu_src_a          = co_out.alu_src_a;
    assign reg_dst            = co_out.reg_dst;
    assign alu_src_b          = co_out.alu_src_b;
    assign alu_op             = co_out.alu_op;
    assign pc_source          = co_out.pc_source;
    assign err_illegal_opcode = co_out.err_illegal_opcode;
    assign state_dbg          = state_reg;

endmodule

// File: tb/tb_multicycle_control_32.sv
// Bench for multicycle_control_32: instruction-level sequence model with per-cycle compare,
// plus directed literal checks on a default instance and a fully de-featured instance.
module tb_multicycle_control_32;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       pcw, pcwc, pcwn, iord, irw, mrd, mwr, m2r, rw, asa;
        logic [1:0] rdst, asb, aop, psrc;
        logic       err;
        logic [3:0] st;
    } ov_t;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] opcode, opcode2;
    logic mem_ready, mem_ready2;

    logic pc_write, pc_write_cond, pc_write_ncond, iord, ir_write, mem_read, mem_write;
    logic mem_toreg, reg_write, alu_src_a, err_illegal_opcode;
    logic [1:0] reg_dst, alu_src_b, alu_op, pc_source;
    logic [3:0] state_dbg;

    logic b_pcw, b_pcwc, b_pcwn, b_iord, b_irw, b_mrd, b_mwr, b_m2r, b_rw, b_asa, b_err;
    logic [1:0] b_rdst, b_asb, b_aop, b_psrc;
    logic [3:0] b_st;

    ov_t act, act2, exp_v;
    bit  exp_on;
    int  total = 0;
    int  bad = 0;

    always #5 clk = ~clk;

    multicycle_control_32 dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_write_ncond(pc_write_ncond),
        .iord(iord), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_toreg(mem_toreg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .reg_dst(reg_dst), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .err_illegal_opcode(err_illegal_opcode), .state_dbg(state_dbg)
    );

    multicycle_control_32 #(.MEM_WAIT_EN(1'b0), .TRAP_ON_ILLEGAL(1'b0), .EXT_OPS_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .opcode(opcode2), .mem_ready(mem_ready2),
        .pc_write(b_pcw), .pc_write_cond(b_pcwc), .pc_write_ncond(b_pcwn),
        .iord(b_iord), .ir_write(b_irw), .mem_read(b_mrd), .mem_write(b_mwr),
        .mem_toreg(b_m2r), .reg_write(b_rw), .alu_src_a(b_asa),
        .reg_dst(b_rdst), .alu_src_b(b_asb), .alu_op(b_aop), .pc_source(b_psrc),
        .err_illegal_opcode(b_err), .state_dbg(b_st)
    );

    assign act  = {pc_write, pc_write_cond, pc_write_ncond, iord, ir_write, mem_read, mem_write,
                   mem_toreg, reg_write, alu_src_a, reg_dst, alu_src_b, alu_op, pc_source,
                   err_illegal_opcode, state_dbg};
    assign act2 = {b_pcw, b_pcwc, b_pcwn, b_iord, b_irw, b_mrd, b_mwr, b_m2r, b_rw, b_asa,
                   b_rdst, b_asb, b_aop, b_psrc, b_err, b_st};

    // Expected control word for one cycle spent in a state (alt = bne / jal flavour).
    function automatic ov_t vec(input state_t st, input bit alt, input bit rdy);
        ov_t v = '0;
        v.st = st;
        case (st)
            S_FETCH:     begin v.mrd = 1; v.asb = 2'b01; v.irw = rdy; v.pcw = rdy; end
            S_DECODE:    v.asb = 2'b11;
            S_MEM_ADDR:  begin v.asa = 1; v.asb = 2'b10; end
            S_MEM_RD:    begin v.mrd = 1; v.iord = 1; end
            S_MEM_WB:    begin v.rw = 1; v.m2r = 1; end
            S_MEM_WR:    begin v.mwr = 1; v.iord = 1; end
            S_R_EXEC:    begin v.asa = 1; v.aop = 2'b10; end
            S_R_WB:      begin v.rw = 1; v.rdst = 2'b01; end
            S_ADDI_EXEC: begin v.asa = 1; v.asb = 2'b10; end
            S_ADDI_WB:   v.rw = 1;
            S_BRANCH:    begin v.asa = 1; v.aop = 2'b01; v.psrc = 2'b01; v.pcwc = !alt; v.pcwn = alt; end
            S_JUMP: begin
                v.pcw = 1; v.psrc = 2'b10;
                if (alt) begin v.rw = 1; v.rdst = 2'b10; v.asb = 2'b01; end
            end
            S_ERROR:     v.err = 1;
            default:     ;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (exp_on) begin
            total++;
            if (act !== exp_v) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t got=%h want=%h", $time, act, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
        end
    endtask

    // One clock spent in state st; called at posedge+1..+2, returns at next posedge+1.
    task automatic cyc(input state_t st, input bit alt, input bit rdy);
        mem_ready = rdy;
        exp_v = vec(st, alt, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input state_t st, input int pct, output int k);
        bit r;
        k = 0;
        do begin
            r = (k >= 6) || ($urandom_range(99) >= pct);
            cyc(st, 1'b0, r);
            k++;
        end while (!r);
    endtask

    task automatic run_instr(input logic [5:0] op, input int pct);
        int n, k;
        wait_state(S_FETCH, pct, n);
        opcode = op;
        cyc(S_DECODE, 1'b0, 1'($urandom));
        n++;
        case (op)
            OP_LW: begin
                cyc(S_MEM_ADDR, 1'b0, 1'($urandom));
                wait_state(S_MEM_RD, pct, k);
                cyc(S_MEM_WB, 1'b0, 1'($urandom));
                n += k + 2;
            end
            OP_SW: begin
                cyc(S_MEM_ADDR, 1'b0, 1'($urandom));
                wait_state(S_MEM_WR, pct, k);
                n += k + 1;
            end
            OP_RTYPE: begin cyc(S_R_EXEC, 0, 1'($urandom)); cyc(S_R_WB, 0, 1'($urandom)); n += 2; end
            OP_ADDI:  begin cyc(S_ADDI_EXEC, 0, 1'($urandom)); cyc(S_ADDI_WB, 0, 1'($urandom)); n += 2; end
            OP_BEQ:   begin cyc(S_BRANCH, 0, 1'($urandom)); n++; end
            OP_BNE:   begin cyc(S_BRANCH, 1, 1'($urandom)); n++; end
            OP_J:     begin cyc(S_JUMP, 0, 1'($urandom)); n++; end
            OP_JAL:   begin cyc(S_JUMP, 1, 1'($urandom)); n++; end
            default:  ;
        endcase
        opcode = 6'($urandom);
        $display("instr op=%b stall_pct=%0d cycles=%0d", op, pct, n);
    endtask

    logic [5:0] ops [8];
    state_t     lw_seq [5];
    logic [7:0] d2_exp [9];

    initial begin
        ops    = '{OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J, OP_JAL};
        lw_seq = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB};
        // {err, reg_write, mem_read, ir_write, state}: bne trap-pulse, then lw with ready ignored
        d2_exp = '{8'b0011_0000, 8'b0000_0001, 8'b1000_1100, 8'b0011_0000, 8'b0000_0001,
                   8'b0000_0010, 8'b0010_0011, 8'b0100_0100, 8'b0011_0000};

        rst = 1'b1; mem_ready = 1'b0; mem_ready2 = 1'b0;
        opcode = 6'd0; opcode2 = OP_BNE;
        exp_v = '0; exp_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'(act[22:4]), 0);
        chk("reset_state", 32'(state_dbg), 0);
        rst = 1'b0;

        // lw, no wait states: five states, reg_write only in the last
        opcode = OP_LW;
        for (int i = 0; i < 5; i++) begin
            #1 chk("lw_seq", {reg_write, state_dbg}, {(i == 4), 4'(i)});
            cyc(lw_seq[i], 1'b0, 1'b1);
        end
        $display("instr op=%b directed lw", OP_LW);

        // sw stalled three cycles in MEM_WR
        opcode = OP_SW;
        cyc(S_FETCH, 0, 1); cyc(S_DECODE, 0, 1); cyc(S_MEM_ADDR, 0, 1);
        for (int i = 0; i < 4; i++) begin
            #1 chk("sw_memwr_hold", {mem_write, mem_read, state_dbg}, {2'b10, 4'd5});
            cyc(S_MEM_WR, 1'b0, (i == 3));
        end
        #1 chk("sw_done_fetch", {mem_write, state_dbg}, 0);
        $display("instr op=%b directed sw stall", OP_SW);

        // bne with extensions enabled
        opcode = OP_BNE;
        cyc(S_FETCH, 0, 1); cyc(S_DECODE, 0, 0);
        #1 chk("bne_branch", {pc_write_ncond, pc_write_cond, state_dbg}, {2'b10, 4'd10});
        cyc(S_BRANCH, 1'b1, 1'b0);
        #1 chk("bne_one_cycle", {pc_write_ncond, state_dbg}, 0);
        $display("instr op=%b directed bne", OP_BNE);

        // jal: jump and link in the same cycle
        opcode = OP_JAL;
        cyc(S_FETCH, 0, 1); cyc(S_DECODE, 0, 1);
        #1 chk("jal_jump", {pc_write, reg_write, reg_dst, pc_source}, 6'b11_10_10);
        cyc(S_JUMP, 1'b1, 1'b1);
        $display("instr op=%b directed jal", OP_JAL);

        repeat (60) run_instr(ops[$urandom_range(7)], ($urandom_range(1) == 1) ? 40 : 0);

        // asynchronous reset in the middle of a stalled MEM_RD
        opcode = OP_LW;
        cyc(S_FETCH, 0, 1); cyc(S_DECODE, 0, 1); cyc(S_MEM_ADDR, 0, 1); cyc(S_MEM_RD, 0, 0);
        #1 chk("rd_stall", {mem_read, iord, state_dbg}, {2'b11, 4'd3});
        #1 rst = 1'b1;
        exp_v = '0;
        #1 chk("rst_async_outs", 32'(act[22:4]), 0);
        chk("rst_async_state", 32'(state_dbg), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("post_rst_fetch", {mem_read, state_dbg}, {1'b1, 4'd0});
        $display("instr op=%b reset mid MEM_RD", OP_LW);

        // illegal opcode traps until reset
        opcode = 6'b111111;
        cyc(S_FETCH, 0, 1); cyc(S_DECODE, 0, 0);
        for (int i = 0; i < 20; i++) begin
            #1 chk("err_sticky", {err_illegal_opcode, state_dbg}, {1'b1, 4'd12});
            cyc(S_ERROR, 1'b0, 1'($urandom));
        end
        #2 rst = 1'b1;
        exp_v = '0;
        #1 chk("err_in_rst", {err_illegal_opcode, state_dbg}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("err_cleared_fetch", {err_illegal_opcode, mem_read, state_dbg}, {2'b01, 4'd0});
        cyc(S_FETCH, 1'b0, 1'b0);
        $display("instr op=111111 trap then reset");

        // de-featured instance: bne illegal with one-cycle err, mem_ready ignored
        exp_on = 1'b0;
        opcode2 = OP_BNE;
        mem_ready2 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #1 chk("d2_seq", {act2.err, act2.rw, act2.mrd, act2.irw, act2.st}, d2_exp[i]);
            if (i == 3) opcode2 = OP_LW;
            @(posedge clk);
        end
        $display("instr dut2 bne-illegal then lw no-wait");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_32.md
MULTICYCLE_CONTROL_32 -- requirements
Module: multicycle_control_32

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1: 1 means memory states stall on mem_ready; 0 means mem_ready is ignored and treated as 1.
REQ-002 SHALL have parameter TRAP_ON_ILLEGAL, default 1: 1 means an illegal opcode enters sticky ERROR; 0 means a one-cycle err pulse followed by FETCH.
REQ-003 SHALL have parameter EXT_OPS_EN, default 1: 1 means bne (6'b000101) and jal (6'b000011) are decoded; 0 means they are illegal.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 ports, in order:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- opcode  in  6  instruction[31:26], valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- pc_write, pc_write_cond, pc_write_ncond  out  1 each  PC update enables
- iord, ir_write, mem_read, mem_write  out  1 each  memory path controls
- mem_toreg, reg_write, alu_src_a  out  1 each  datapath selects
- reg_dst  out  2  00 rt, 01 rd, 10 $ra
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
- err_illegal_opcode  out  1  illegal opcode flag
- state_dbg  out  4  current state encoding

Function
REQ-006 SHALL implement states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP, ERROR.
REQ-007 Outputs SHALL be decoded from the registered state (Moore); the only exception is the gating in REQ-008.
REQ-008 FETCH: mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write SHALL assert only in the cycle mem_ready=1, and FETCH SHALL then advance to DECODE; otherwise it holds.
REQ-009 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, with the opcode sampled this cycle. Transitions: lw/sw→MEM_ADDR, r_type→R_EXEC, addi→ADDI_EXEC, beq/bne→BRANCH, j/jal→JUMP, other→ERROR.
REQ-010 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw→MEM_RD, sw→MEM_WR.
REQ-011 MEM_RD: mem_read=1, iord=1; advances to MEM_WB when mem_ready, else holds.
REQ-012 MEM_WB: reg_write=1, mem_toreg=1, reg_dst=00; then FETCH.
REQ-013 MEM_WR: mem_write=1, iord=1; advances to FETCH when mem_ready, else holds, with mem_write held stable throughout.
REQ-014 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; then R_WB, which asserts reg_write=1, reg_dst=01, mem_toreg=0; then FETCH.
REQ-015 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; then ADDI_WB, which asserts reg_write=1, reg_dst=00; then FETCH.
REQ-016 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01; asserts pc_write_cond for beq or pc_write_ncond for bne; then FETCH.
REQ-017 JUMP: pc_write=1, pc_source=10; for jal also reg_write=1, reg_dst=10, mem_toreg=0, alu_src_a=0, alu_src_b=01; then FETCH.
REQ-018 ERROR: all enables 0, err_illegal_opcode=1. With TRAP_ON_ILLEGAL=1 it holds until rst; with 0 it lasts exactly one cycle, then FETCH.
REQ-019 Any output not listed for a state SHALL be 0; mem_read and mem_write SHALL never assert together.
REQ-020 Latencies with no wait states SHALL be: lw 5 cycles, sw 4, r_type 4, addi 4, beq/bne 3, j/jal 3.

Reset
REQ-021 rst SHALL asynchronously force the state to FETCH and all outputs to 0 while asserted, including mid-instruction and mid-stall.
REQ-022 After rst deasserts, FETCH behaviour SHALL begin at the first rising edge.

Structure
REQ-023 Opcode constants, state encodings (4-bit), and alu_op, alu_src_b and pc_source codes SHALL live in shared package mips_ctrl_pkg.
REQ-024 Opcode classification SHALL be one combinational sub-module, ctrl_opcode_class, shared with the single-cycle decoder.

Verification
REQ-025 lw (opcode 100011), mem_ready tied 1 → states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; reg_write=1 only in cycle 5.
REQ-026 sw with mem_ready low for 3 cycles in MEM_WR → mem_write held high 4 cycles, exactly one transition to FETCH.
REQ-027 opcode 111111, TRAP_ON_ILLEGAL=1 → ERROR; err=1 held for 20 cycles; rst pulse → FETCH, err=0.
REQ-028 bne (000101) with EXT_OPS_EN=0 → ERROR; with EXT_OPS_EN=1 → pc_write_ncond=1 for one cycle and pc_write_cond=0.
REQ-029 jal (000011) → JUMP asserts pc_write=1, reg_write=1, reg_dst=10, pc_source=10 in the same cycle.
REQ-030 rst asserted asynchronously mid-cycle in MEM_RD → outputs 0 immediately, state_dbg=FETCH encoding.
